// File: rtl/uart_rx_top.sv
// UART receiver: 1 start, 8 data bits LSB-first, even parity, 1 stop.
// The line is oversampled by CLKS_PER_BIT and each bit is sampled at its centre.
module uart_rx_top #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t        r_state, w_state_next;
  logic          r_sync1, r_sync2;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]    r_bitidx, w_bitidx_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          r_par, w_par_next;
  logic [7:0]    r_data, w_data_next;
  logic          r_done, w_done_next;
  logic          r_perr, w_perr_next;
  logic          r_ferr, w_ferr_next;
  logic          r_busy;

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_bitidx_next = r_bitidx;
    w_shift_next  = r_shift;
    w_par_next    = r_par;
    w_data_next   = r_data;
    w_done_next   = 1'b0;
    w_perr_next   = r_perr;
    w_ferr_next   = r_ferr;
    case (r_state)
      S_IDLE: begin
        if (!r_sync2) begin
          if (HALF == 0) begin
            w_state_next  = S_DATA;
            w_cnt_next    = '0;
            w_bitidx_next = 3'd0;
          end else begin
            w_state_next = S_START;
            w_cnt_next   = ONE;
          end
        end
      end
      S_START: begin
        w_cnt_next = r_cnt + ONE;
        if (r_cnt == HALF_C) begin
          // A line back high at mid-start is a glitch, not a frame
          w_cnt_next = '0;
          if (!r_sync2) begin
            w_state_next  = S_DATA;
            w_bitidx_next = 3'd0;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        w_cnt_next = r_cnt + ONE;
        if (r_cnt == LAST) begin
          w_shift_next[r_bitidx] = r_sync2;
          w_cnt_next = '0;
          if (r_bitidx == 3'd7) w_state_next = S_PARITY;
          else                  w_bitidx_next = r_bitidx + 3'd1;
        end
      end
      S_PARITY: begin
        w_cnt_next = r_cnt + ONE;
        if (r_cnt == LAST) begin
          w_par_next   = r_sync2;
          w_cnt_next   = '0;
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        w_cnt_next = r_cnt + ONE;
        if (r_cnt == LAST) begin
          w_data_next  = r_shift;
          w_perr_next  = r_par ^ (^r_shift);
          w_ferr_next  = ~r_sync2;
          w_done_next  = 1'b1;
          w_cnt_next   = '0;
          w_state_next = r_sync2 ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        // A held-low line after a bad stop bit must not look like a new start
        w_cnt_next = '0;
        if (r_sync2) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bitidx <= 3'd0;
      r_shift  <= 8'h00;
      r_par    <= 1'b0;
      r_data   <= 8'h00;
      r_done   <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_sync1  <= data_in;
      r_sync2  <= r_sync1;
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_bitidx <= w_bitidx_next;
      r_shift  <= w_shift_next;
      r_par    <= w_par_next;
      r_data   <= w_data_next;
      r_done   <= w_done_next;
      r_perr   <= w_perr_next;
      r_ferr   <= w_ferr_next;
      r_busy   <= (w_state_next != S_IDLE);
    end
  end

  assign data_out   = r_data;
  assign rx_done    = r_done;
  assign rx_busy    = r_busy;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;

endmodule

// File: tb/tb_uart_rx_top.sv
// Bench for uart_rx_top: one receiver at 1 clock/bit, one at 16 clocks/bit,
// checked against frame-level expectations derived from the frame format.
module tb_uart_rx_top;

  typedef struct packed {
    int         cyc;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic line_a = 1'b1, line_b = 1'b1;
  logic [7:0] dout_a, dout_b;
  logic done_a, done_b, busy_a, busy_b, pe_a, pe_b, fe_a, fe_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int bcnt_a = 0, bcnt_b = 0;
  rec_t obs_a[$], obs_b[$], exp_a[$], exp_b[$];

  uart_rx_top #(.CLKS_PER_BIT(1)) dut_a (
    .clk(clk), .rst(rst), .data_in(line_a), .data_out(dout_a), .rx_done(done_a),
    .rx_busy(busy_a), .parity_err(pe_a), .frame_err(fe_a));

  uart_rx_top #(.CLKS_PER_BIT(16)) dut_b (
    .clk(clk), .rst(rst), .data_in(line_b), .data_out(dout_b), .rx_done(done_b),
    .rx_busy(busy_b), .parity_err(pe_b), .frame_err(fe_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done_a) obs_a.push_back('{cyc, dout_a, pe_a, fe_a});
    if (done_b) obs_b.push_back('{cyc, dout_b, pe_b, fe_b});
    if (busy_a) bcnt_a++;
    if (busy_b) bcnt_b++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame; done is expected 2+HALF+10*cpb edges after the first low sample
  task automatic send_frame(input int which, input logic [7:0] d, input logic pbit,
                            input logic sbit, input int gap);
    int cpb, half, s;
    logic [10:0] bits;
    cpb  = (which != 0) ? 16 : 1;
    half = (cpb - 1) / 2;
    bits = {sbit, pbit, d, 1'b0};
    s    = cyc;
    for (int i = 0; i < 11; i++) begin
      if (which != 0) line_b = bits[i]; else line_a = bits[i];
      tick(cpb);
    end
    if (which != 0) exp_b.push_back('{s + 3 + half + 10 * cpb, d, pbit ^ (^d), ~sbit});
    else            exp_a.push_back('{s + 3 + half + 10 * cpb, d, pbit ^ (^d), ~sbit});
    if (gap > 0) begin
      if (which != 0) line_b = 1'b1; else line_a = 1'b1;
      tick(gap * cpb);
    end
  endtask

  task automatic clear_q();
    obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic test_reset();
    tick(3);
    total++;
    if ({dout_a, done_a, busy_a, pe_a, fe_a} !== 12'h000) begin
      bad++; $display("FAIL reset_a got=%h want=000", {dout_a, done_a, busy_a, pe_a, fe_a});
    end
    total++;
    if ({dout_b, done_b, busy_b, pe_b, fe_b} !== 12'h000) begin
      bad++; $display("FAIL reset_b got=%h want=000", {dout_b, done_b, busy_b, pe_b, fe_b});
    end
    rst = 1'b1;
    tick(2);
    line_a = 1'b0;
    tick(5);
    total++;
    if (busy_a !== 1'b1) begin
      bad++; $display("FAIL reset_midframe_busy got=%b want=1", busy_a);
    end
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    line_a = 1'b1;
    total++;
    if (busy_a !== 1'b0) begin
      bad++; $display("FAIL reset_busy_after got=%b want=0", busy_a);
    end
    tick(20);
    total++;
    if (obs_a.size() !== 0 || {dout_a, busy_a, pe_a, fe_a} !== 11'h000) begin
      bad++; $display("FAIL reset_abandon dones=%0d outs=%h want 0/000", obs_a.size(),
                      {dout_a, busy_a, pe_a, fe_a});
    end
    $display("reset: mid-frame reset abandoned, dones=%0d", obs_a.size());
  endtask

  task automatic test_basic();
    clear_q();
    bcnt_a = 0;
    send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
    tick(20);
    total++;
    if (bcnt_a !== 10) begin
      bad++; $display("FAIL basic_busy_cycles got=%0d want=10", bcnt_a);
    end
    total++;
    if (obs_a.size() !== 1 || exp_a.size() !== 1 || obs_a[0] !== exp_a[0]) begin
      bad++; $display("FAIL basic_frame got n=%0d %p want %p", obs_a.size(), obs_a, exp_a);
    end
    $display("basic: data=%h pe=%b fe=%b", dout_a, pe_a, fe_a);
  endtask

  task automatic test_parity();
    clear_q();
    send_frame(0, 8'h07, 1'b0, 1'b1, 0);
    tick(20);
    total++;
    if (obs_a.size() !== 1 || obs_a[0] !== exp_a[0] || obs_a[0].pe !== 1'b1) begin
      bad++; $display("FAIL parity_err got n=%0d %p want %p", obs_a.size(), obs_a, exp_a);
    end
    $display("parity: data=%h pe=%b fe=%b", dout_a, pe_a, fe_a);
  endtask

  task automatic test_break();
    clear_q();
    send_frame(0, 8'h3C, ^8'h3C, 1'b0, 0);
    tick(20);
    total++;
    if (busy_a !== 1'b1 || obs_a.size() !== 1) begin
      bad++; $display("FAIL break_hold busy=%b dones=%0d want busy=1 dones=1", busy_a, obs_a.size());
    end
    line_a = 1'b1;
    tick(3);
    send_frame(0, 8'h81, ^8'h81, 1'b1, 0);
    tick(20);
    total++;
    if (obs_a.size() !== 2) begin
      bad++; $display("FAIL break_count got=%0d want=2", obs_a.size());
    end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      total++;
      if (obs_a[i] !== exp_a[i]) begin
        bad++; $display("FAIL break_frame%0d got=%p want=%p", i, obs_a[i], exp_a[i]);
      end
    end
    $display("break: data=%h pe=%b fe=%b", dout_a, pe_a, fe_a);
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_frame(0, 8'h55, ^8'h55, 1'b1, 0);
    send_frame(0, 8'hFF, ^8'hFF, 1'b1, 0);
    tick(20);
    total++;
    if (obs_a.size() !== 2 || (obs_a[1].cyc - obs_a[0].cyc) !== 11) begin
      bad++; $display("FAIL b2b_spacing n=%0d got=%p want spacing 11", obs_a.size(), obs_a);
    end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      total++;
      if (obs_a[i] !== exp_a[i]) begin
        bad++; $display("FAIL b2b_frame%0d got=%p want=%p", i, obs_a[i], exp_a[i]);
      end
    end
    $display("back_to_back: dones=%0d", obs_a.size());
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic pbit, sbit;
    int gap;
    clear_q();
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      pbit = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
      sbit = ($urandom_range(0, 4) != 0);
      gap  = $urandom_range(0, 2);
      if (!sbit && gap == 0) gap = 1;
      send_frame(0, d, pbit, sbit, gap);
    end
    line_a = 1'b1;
    tick(20);
    total++;
    if (obs_a.size() !== exp_a.size()) begin
      bad++; $display("FAIL rand_count got=%0d want=%0d", obs_a.size(), exp_a.size());
    end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      total++;
      if (obs_a[i] !== exp_a[i]) begin
        bad++; $display("FAIL rand_frame%0d got=%p want=%p", i, obs_a[i], exp_a[i]);
      end
      $display("rand %0d: data=%h pe=%b fe=%b", i, obs_a[i].d, obs_a[i].pe, obs_a[i].fe);
    end
  endtask

  task automatic test_oversample();
    logic [7:0] d;
    clear_q();
    send_frame(1, 8'h5A, ^8'h5A, 1'b1, 2);
    for (int n = 0; n < 3; n++) begin
      d = 8'($urandom);
      send_frame(1, d, ($urandom_range(0, 1) != 0) ? ^d : ~(^d), 1'b1, $urandom_range(0, 1));
    end
    send_frame(1, 8'h5A, ^8'h5A, 1'b1, 2);
    tick(40);
    total++;
    if (obs_b.size() !== exp_b.size()) begin
      bad++; $display("FAIL over_count got=%0d want=%0d", obs_b.size(), exp_b.size());
    end
    for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
      total++;
      if (obs_b[i] !== exp_b[i]) begin
        bad++; $display("FAIL over_frame%0d got=%p want=%p", i, obs_b[i], exp_b[i]);
      end
      $display("over %0d: data=%h pe=%b fe=%b", i, obs_b[i].d, obs_b[i].pe, obs_b[i].fe);
    end
    bcnt_b = 0;
    line_b = 1'b0;
    tick(4);
    line_b = 1'b1;
    tick(40);
    total++;
    if (bcnt_b == 0 || obs_b.size() !== exp_b.size() || {dout_b, pe_b, fe_b, busy_b} !== {8'h5A, 3'b000}) begin
      bad++; $display("FAIL glitch busy_cycles=%0d dones=%0d outs=%h want busy>0 dones=%0d outs=5a0",
                      bcnt_b, obs_b.size(), {dout_b, pe_b, fe_b, busy_b}, exp_b.size());
    end
    $display("glitch: busy_cycles=%0d dones=%0d", bcnt_b, obs_b.size());
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_back_to_back();
    test_random();
    test_oversample();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
